// File: rtl/bs_host_if_pkg.sv
// Shared register map, status field positions and FSM states for the Black-Scholes host bridge.
package bs_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STAT   = 3'd1;
    localparam logic [2:0] ADDR_K      = 3'd2;
    localparam logic [2:0] ADDR_C1     = 3'd3;
    localparam logic [2:0] ADDR_C2     = 3'd4;
    localparam logic [2:0] ADDR_C3     = 3'd5;
    localparam logic [2:0] ADDR_RESULT = 3'd6;
    localparam logic [2:0] ADDR_CYCLES = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_CLR = 1;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_PERR     = 3;
    localparam int STAT_LAST_LSB = 4;
    localparam int STAT_LAST_MSB = 8;
    localparam int STAT_W        = STAT_LAST_MSB + 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR_LSB = 2;
    localparam int ST_ERR_MSB = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/bs_host_if_if.sv
// Host bus and processor operand/result bundles; the bridge is the bus slave and the processor master.
interface bs_bus_if;
    logic [2:0]  bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic [31:0] bus_rdata;

    modport master (output bus_addr, bus_wr, bus_wdata, bus_rd, input bus_rdata);
    modport slave  (input bus_addr, bus_wr, bus_wdata, bus_rd, output bus_rdata);
endinterface

interface bs_proc_if;
    logic [31:0] constK;
    logic [31:0] const1;
    logic [31:0] const2;
    logic [31:0] const3;
    logic        req;
    logic [4:0]  status;
    logic [31:0] dout;

    modport master (output constK, const1, const2, const3, req, input status, dout);
    modport slave  (input constK, const1, const2, const3, req, output status, dout);
endinterface

// File: rtl/bs_host_if_regs.sv
// Bus decode, operand registers and registered read mux for the host bridge.
// Latency: writes land on the strobe edge, read data valid the cycle after bus_rd.
// Backpressure: none; operand writes are dropped while a transaction is busy.
module bs_host_regs
    import bs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    bs_bus_if.slave           bus,
    input  logic              busy_i,
    input  logic [STAT_W-1:0] stat_i,
    input  logic [31:0]       result_i,
    input  logic [CNT_W-1:0]  cycles_i,
    output logic              start_o,
    output logic              irq_clr_o,
    output logic [31:0]       k_o,
    output logic [31:0]       c1_o,
    output logic [31:0]       c2_o,
    output logic [31:0]       c3_o
);

    logic [31:0] k_q, c1_q, c2_q, c3_q;
    logic [31:0] rdata_q, rd_mux;
    logic        wr_ctrl, wr_op;

    assign wr_ctrl   = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);
    assign start_o   = wr_ctrl && bus.bus_wdata[CTRL_START];
    assign irq_clr_o = wr_ctrl && bus.bus_wdata[CTRL_IRQ_CLR];

    // Operands freeze during a transaction so the processor never sees them move.
    assign wr_op = bus.bus_wr && !busy_i;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            k_q  <= '0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else if (wr_op) begin
            case (bus.bus_addr)
                ADDR_K:  k_q  <= bus.bus_wdata;
                ADDR_C1: c1_q <= bus.bus_wdata;
                ADDR_C2: c2_q <= bus.bus_wdata;
                ADDR_C3: c3_q <= bus.bus_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_STAT:   rd_mux = 32'(stat_i);
            ADDR_K:      rd_mux = k_q;
            ADDR_C1:     rd_mux = c1_q;
            ADDR_C2:     rd_mux = c2_q;
            ADDR_C3:     rd_mux = c3_q;
            ADDR_RESULT: rd_mux = result_i;
            ADDR_CYCLES: rd_mux = 32'(cycles_i);
            default:     rd_mux = '0;
        endcase
    end

    // Sampling before any same-cycle write lands gives read-before-write ordering.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata_q <= '0;
        end else if (bus.bus_rd) begin
            rdata_q <= rd_mux;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign k_o  = k_q;
    assign c1_o = c1_q;
    assign c2_o = c2_q;
    assign c3_o = c3_q;

endmodule

// File: rtl/bs_host_if.sv
// Host bridge driving the Black-Scholes processor request and capturing its result; BS_HOST_IRQ_EN enables irq.
// Latency: req one cycle after START, done in STAT two cycles after processor done is seen.
// Backpressure: none; START and operand writes are ignored while busy, WAIT aborts after TIMEOUT_CYCLES.
module bs_host_if
    import bs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       nreset,
    bs_bus_if.slave    bus,
    bs_proc_if.master  proc,
    output logic       irq
);

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cycles_q;
    logic [31:0]         result_q;
    logic [4:0]          last_st_q;
    logic                done_q, timeout_q, perr_q;
    logic                busy, start, irq_clr, enter_done;
    logic [STAT_W-1:0]   stat;

    bs_host_regs #(.CNT_W(CNT_W)) u_regs (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .busy_i    (busy),
        .stat_i    (stat),
        .result_i  (result_q),
        .cycles_i  (cycles_q),
        .start_o   (start),
        .irq_clr_o (irq_clr),
        .k_o       (proc.constK),
        .c1_o      (proc.const1),
        .c2_o      (proc.const2),
        .c3_o      (proc.const3)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (proc.status[ST_DONE]) begin
                    state_d = CAP;
                end else if (cycles_q >= CYC_LAST) begin
                    state_d = DONE;
                end
            end
            CAP:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == REQ) || (state_q == WAIT) || (state_q == CAP);
    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign proc.req   = (state_q == REQ);

    // CYCLES is the number of cycles spent in WAIT, including the one that leaves it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cycles_q  <= '0;
            result_q  <= '0;
            last_st_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                cycles_q  <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                perr_q    <= 1'b0;
            end
            if (state_q == WAIT && cycles_q != '1) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (state_q == WAIT && state_d == DONE) begin
                timeout_q <= 1'b1;
            end
            if (state_q == CAP) begin
                result_q  <= proc.dout;
                perr_q    <= |proc.status[ST_ERR_MSB:ST_ERR_LSB];
                last_st_q <= proc.status;
            end
            if (enter_done) begin
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        stat = '0;
        stat[STAT_BUSY]                     = busy;
        stat[STAT_DONE]                     = done_q;
        stat[STAT_TIMEOUT]                  = timeout_q;
        stat[STAT_PERR]                     = perr_q;
        stat[STAT_LAST_MSB:STAT_LAST_LSB]   = last_st_q;
    end

`ifdef BS_HOST_IRQ_EN
    logic irq_q;

    // A completion arriving alongside a clear must not be lost, so set wins.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_q <= 1'b0;
        end else if (enter_done) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bs_host_if.sv
// Directed bench for bs_host_if: register table, normal/error/busy/timeout runs, async reset and irq.
`timescale 1ns/1ps
module tb_bs_host_if;
    import bs_pkg::*;

`ifdef BS_HOST_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic irq;
    int   checks = 0;
    int   failures = 0;
    int   req_total = 0;

    bs_bus_if  bus();
    bs_proc_if proc();

    bs_host_if dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus),
        .proc   (proc),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (proc.req === 1'b1) req_total++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_wr    = 1'b1;
        @(negedge clk);
        bus.bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.bus_addr = a;
        bus.bus_rd   = 1'b1;
        @(negedge clk);
        bus.bus_rd   = 1'b0;
        d = bus.bus_rdata;
    endtask

    // START, then present processor status/dout 'dly' cycles after WAIT is entered.
    task automatic run_txn(input string tag, input logic [4:0] st, input logic [31:0] dv, input int dly);
        int r0;
        r0 = req_total;
        bus_write(ADDR_CTRL, 32'h1);
        check({tag, "_req_after_start"}, 32'(proc.req), 32'h1);
        for (int k = 1; k <= dly; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check({tag, "_req_one_cycle"}, 32'(proc.req), 32'h0);
        end
        proc.status = st;
        proc.dout   = dv;
        repeat (4) @(posedge clk);
        #1;
        proc.status = '0;
        proc.dout   = '0;
        @(negedge clk);
        check({tag, "_req_pulses"}, 32'(req_total - r0), 32'h1);
    endtask

    initial begin
        vec_t        vt[8];
        logic [31:0] rd;
        int          n;
        int          r0;

        bus.bus_addr  = '0;
        bus.bus_wr    = 1'b0;
        bus.bus_wdata = '0;
        bus.bus_rd    = 1'b0;
        proc.status   = '0;
        proc.dout     = '0;

        vt[0] = '{ADDR_K,      1'b1, 32'h3F9E0419, 32'h3F9E0419};
        vt[1] = '{ADDR_C1,     1'b1, 32'h00000001, 32'h00000001};
        vt[2] = '{ADDR_C2,     1'b1, 32'h00000002, 32'h00000002};
        vt[3] = '{ADDR_C3,     1'b1, 32'h00000003, 32'h00000003};
        vt[4] = '{ADDR_RESULT, 1'b1, 32'hDEADBEEF, 32'h00000000};
        vt[5] = '{ADDR_STAT,   1'b1, 32'h000001FF, 32'h00000000};
        vt[6] = '{ADDR_CYCLES, 1'b1, 32'h0000FFFF, 32'h00000000};
        vt[7] = '{ADDR_K,      1'b0, 32'h00000000, 32'h3F9E0419};

        repeat (3) @(negedge clk);
        nreset = 1'b1;

        // Reset state
        check("rst_req", 32'(proc.req), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_constK", proc.constK, 32'h0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_rd%0d", a), rd, 32'h0);
        end

        // Register table
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].wdata);
            bus_read(vt[i].addr, rd);
            check($sformatf("tbl%0d_addr%0d", i, vt[i].addr), rd, vt[i].exp);
        end
        check("port_constK", proc.constK, 32'h3F9E0419);
        check("port_const1", proc.const1, 32'h1);
        check("port_const2", proc.const2, 32'h2);
        check("port_const3", proc.const3, 32'h3);

        // Basic run
        run_txn("basic", 5'b00010, 32'h46410000, 15);
        bus_read(ADDR_RESULT, rd); check("basic_result", rd, 32'h46410000);
        bus_read(ADDR_STAT, rd);   check("basic_stat", rd, 32'h022);
        bus_read(ADDR_CYCLES, rd); check("basic_cycles", rd, 32'd15);
        check("basic_irq_set", 32'(irq), 32'(IRQ_ON));
        bus_write(ADDR_CTRL, 32'h2);
        check("irq_cleared", 32'(irq), 32'h0);

        // Read and write in the same cycle
        @(negedge clk);
        bus.bus_addr  = ADDR_K;
        bus.bus_wdata = 32'hAAAA5555;
        bus.bus_wr    = 1'b1;
        bus.bus_rd    = 1'b1;
        @(negedge clk);
        bus.bus_wr = 1'b0;
        bus.bus_rd = 1'b0;
        check("rw_old_value", bus.bus_rdata, 32'h3F9E0419);
        bus_read(ADDR_K, rd); check("rw_new_value", rd, 32'hAAAA5555);

        // Processor error status
        run_txn("err", 5'b01010, 32'h12345678, 5);
        bus_read(ADDR_STAT, rd);   check("err_stat", rd, 32'h0AA);
        bus_read(ADDR_RESULT, rd); check("err_result", rd, 32'h12345678);
        bus_read(ADDR_CYCLES, rd); check("err_cycles", rd, 32'd5);

        // Busy protection: operand write and second START during WAIT
        r0 = req_total;
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(ADDR_K, 32'hFFFFFFFF);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_STAT, rd); check("busy_flag", 32'(rd[0]), 32'h1);
        check("busy_constK_port", proc.constK, 32'hAAAA5555);
        bus_read(ADDR_K, rd); check("busy_constK_reg", rd, 32'hAAAA5555);
        @(negedge clk);
        proc.status = 5'b00010;
        proc.dout   = 32'h0BADF00D;
        repeat (4) @(negedge clk);
        proc.status = '0;
        proc.dout   = '0;
        repeat (3) @(negedge clk);
        check("busy_req_pulses", 32'(req_total - r0), 32'h1);
        bus_read(ADDR_RESULT, rd); check("busy_result", rd, 32'h0BADF00D);
        bus_read(ADDR_STAT, rd);   check("busy_stat", rd, 32'h022);

        // Timeout: processor never reports done
        bus_write(ADDR_CTRL, 32'h1);
        n = 0;
        do begin
            bus_read(ADDR_STAT, rd);
            n++;
        end while (rd[1] !== 1'b1 && n < 10500);
        check("to_bounded", 32'(n < 10500), 32'h1);
        check("to_stat", rd, 32'h026);
        bus_read(ADDR_RESULT, rd); check("to_result_kept", rd, 32'h0BADF00D);
        bus_read(ADDR_CYCLES, rd); check("to_cycles", rd, 32'd10000);

        // Async reset while req is high
        bus_write(ADDR_CTRL, 32'h1);
        check("pre_rst_req", 32'(proc.req), 32'h1);
        #1 nreset = 1'b0;
        #1;
        check("arst_req", 32'(proc.req), 32'h0);
        check("arst_constK", proc.constK, 32'h0);
        check("arst_const1", proc.const1, 32'h0);
        check("arst_rdata", bus.bus_rdata, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        nreset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("arst_rd%0d", a), rd, 32'h0);
        end
        run_txn("post_rst", 5'b00010, 32'h40490FDB, 3);
        bus_read(ADDR_RESULT, rd); check("post_rst_result", rd, 32'h40490FDB);
        bus_read(ADDR_CYCLES, rd); check("post_rst_cycles", rd, 32'd3);
        bus_read(ADDR_STAT, rd);   check("post_rst_stat", rd, 32'h022);
        check("post_rst_irq", 32'(irq), 32'(IRQ_ON));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bs_host_if.md
Name: bs_host_if

Overview:
- Host-side register bridge that drives the Black-Scholes processor's operand/request interface and collects its result.
- Software writes constK/const1/const2/const3 over a simple memory-mapped bus and sets START.
- Block holds req, waits for the processor's done status, latches dout, and exposes result, status and cycle count to the bus.
- Sits between the HPS/bus fabric and the processor instance.

Parameters:
- TIMEOUT_CYCLES, 10000, max cycles in WAIT before aborting with timeout.
- CNT_W, 16, width of the cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single system clock.
- nreset  in  1  asynchronous, active-low reset.
- bus_addr  in  3  register word address.
- bus_wr  in  1  write strobe, one cycle per write.
- bus_wdata  in  32  write data.
- bus_rd  in  1  read strobe.
- bus_rdata  out  32  read data, valid the cycle after bus_rd.
- constK, const1, const2, const3  out  32 each  operand registers to the processor.
- req  out  1  request to the processor.
- status  in  5  processor status: [0] busy, [1] done, [4:2] error code (0 = ok).
- dout  in  32  processor result, valid while status[1]=1.
- irq  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Register map (word addresses):
  - 0 CTRL (W): bit0 START (write-1 pulse), bit1 IRQ_CLR.
  - 1 STAT (R): [0] busy, [1] done, [2] timeout, [3] proc_err, [8:4] last sampled status.
  - 2..5: K, C1, C2, C3 (R/W).
  - 6 RESULT (R).
  - 7 CYCLES (R, zero-extended).
- Reset: all constants, RESULT, CYCLES, bus_rdata = 0; req = 0; irq = 0; STAT = 0; FSM = IDLE.
- FSM states:
  - IDLE: START write -> REQ; clears done/timeout/proc_err and CYCLES.
  - REQ: req=1 for exactly one cycle -> WAIT.
  - WAIT: req held 0; CYCLES increments each cycle.
    - status[1]=1 -> CAP.
    - CYCLES reaches TIMEOUT_CYCLES-1 with no done -> DONE with timeout=1; RESULT unchanged.
  - CAP: RESULT <= dout; proc_err <= (status[4:2]!=0); last status sampled -> DONE.
  - DONE: done=1, busy=0 -> IDLE next cycle. The sticky done flag persists until the next START.
- busy = 1 in REQ, WAIT and CAP.
- START latency: req asserted the cycle after the CTRL write; done visible in STAT two cycles after status[1] is first seen high.
- Writes to addresses 2..5 while busy are ignored; operand outputs stay stable for the whole transaction.
- START while busy is ignored (no restart, no error).
- Writes to read-only addresses are ignored. Reads of any address are legal at any time.
- bus_rd and bus_wr in the same cycle: the write takes effect; read returns the pre-write value.
- CYCLES saturates at all-ones; it never wraps.
- nreset asserted mid-transaction: immediate return to reset values; req drops asynchronously.

Optional Feature:
- Macro: BS_HOST_IRQ_EN.
- Defined: irq sets on entry to DONE (normal or timeout) and stays high until a CTRL write with IRQ_CLR=1. Set and clear in the same cycle: set wins.
- Undefined: irq tied to 0; IRQ_CLR ignored.

Decomposition:
- Shared package bs_pkg holds:
  - register address constants (ADDR_CTRL..ADDR_CYCLES);
  - STAT bit positions;
  - processor status field positions (ST_BUSY, ST_DONE, ST_ERR_LSB/MSB);
  - FSM state enumeration (IDLE, REQ, WAIT, CAP, DONE).
- One natural sub-module: bs_host_regs (bus decode, operand registers, read mux); the FSM and counter stay in the top.

Test Plan:
- Basic run:
  - Stimulus: write K=0x3F9E0419, C1..C3 = 1,2,3; write CTRL=1; model asserts status=5'b00010 with dout=0x46410000 after 15 cycles.
  - Response: req high exactly one cycle; RESULT=0x46410000; STAT done=1, proc_err=0; CYCLES=15.
- Timeout:
  - Stimulus: START; model never asserts done.
  - Response: after 10000 cycles in WAIT, STAT timeout=1, done=1, busy=0; RESULT keeps its prior value.
- Busy protection:
  - Stimulus: START, then during WAIT write K=0xFFFFFFFF and CTRL=1.
  - Response: constK unchanged; no second req pulse.
- Error status:
  - Stimulus: model returns status=5'b01010.
  - Response: proc_err=1; STAT[8:4]=5'b01010.
- Async reset mid-WAIT:
  - Stimulus: drop nreset.
  - Response: req=0 and all registers=0 immediately; next START after release works normally.
- IRQ (BS_HOST_IRQ_EN defined):
  - Stimulus: complete a run, then write CTRL=2.
  - Response: irq high after DONE; low the cycle after the clear write.
  - With the macro undefined: irq stays 0 throughout.
